// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: widths, the broadcast packet type and round-robin helper.
// The issue queue imports the same package so tag widths stay in lockstep.
package cdb_arbiter_pkg;

  localparam int NUM_SRC = 4;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_pkt_t;

  // Pointer to the source after the granted one, wrapping mod 4.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result sources and Common Data Bus signals between the FUs and the broadcast arbiter.
interface cdb_arbiter_if import cdb_arbiter_pkg::*; ();

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      CDB_valid;
  logic [TAG_W-1:0]          CDB_tag;
  logic [DATA_W-1:0]         CDB_data;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, CDB_valid, CDB_tag, CDB_data
  );

  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, CDB_valid, CDB_tag, CDB_data
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Two-entry result buffer for one functional unit; a full buffer refuses pushes
// even when it is popped in the same cycle.
module cdb_src_fifo import cdb_arbiter_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_pkt_t   wr_pkt,
  output cdb_pkt_t   head,
  output logic [1:0] count,
  output logic       ready
);

  cdb_pkt_t   mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;
  logic       push_s;
  logic       pop_s;

  assign ready  = (count_r < 2'd2) && !reset && !flush;
  assign push_s = push && ready;
  assign pop_s  = pop && (count_r != 2'd0) && !reset && !flush;
  assign head   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Storage, pointers and occupancy; reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_pkt;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter over four result buffers driving the registered Common Data Bus.
module cdb_arbiter import cdb_arbiter_pkg::*; (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  cdb_pkt_t           head_s   [NUM_SRC];
  cdb_pkt_t           wr_pkt_s [NUM_SRC];
  logic [1:0]         count_s  [NUM_SRC];
  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] grant_s;
  logic [NUM_SRC-1:0] ready_s;
  logic               grant_any_s;
  logic [1:0]         grant_idx_s;
  logic [1:0]         cand_s;
  logic [1:0]         rr_ptr_r;
  logic               cdb_valid_r;
  logic [TAG_W-1:0]   cdb_tag_r;
  logic [DATA_W-1:0]  cdb_data_r;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign wr_pkt_s[g].tag  = bus.src_tag[g*TAG_W +: TAG_W];
    assign wr_pkt_s[g].data = bus.src_data[g*DATA_W +: DATA_W];
    assign req_s[g]         = (count_s[g] != 2'd0);

    cdb_src_fifo u_fifo (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .push   (bus.src_valid[g]),
      .pop    (grant_s[g]),
      .wr_pkt (wr_pkt_s[g]),
      .head   (head_s[g]),
      .count  (count_s[g]),
      .ready  (ready_s[g])
    );
  end

  assign bus.src_ready = ready_s;
  assign bus.CDB_valid = cdb_valid_r;
  assign bus.CDB_tag   = cdb_tag_r;
  assign bus.CDB_data  = cdb_data_r;

  // First requester at or after rr_ptr wins; pops are suppressed under reset/flush.
  always_comb begin
    grant_s     = '0;
    grant_any_s = 1'b0;
    grant_idx_s = rr_ptr_r;
    cand_s      = rr_ptr_r;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand_s = rr_ptr_r + 2'(k);
      if (!grant_any_s && req_s[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (grant_any_s && !reset && !flush) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Broadcast register and round-robin pointer; flush clears the bus but keeps rr_ptr.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r    <= 2'd0;
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= '0;
      cdb_data_r  <= '0;
    end else if (flush) begin
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= '0;
      cdb_data_r  <= '0;
    end else if (grant_any_s) begin
      rr_ptr_r    <= rr_next(grant_idx_s);
      cdb_valid_r <= 1'b1;
      cdb_tag_r   <= head_s[grant_idx_s].tag;
      cdb_data_r  <= head_s[grant_idx_s].data;
    end else begin
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= '0;
      cdb_data_r  <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round robin, fairness,
// back-pressure, flush and mid-stream reset with hand-computed broadcasts.
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_cdb(input string name, input logic v, input logic [5:0] t, input logic [31:0] d);
    chk({name, "_valid"}, {63'd0, bus.CDB_valid}, {63'd0, v});
    chk({name, "_tag"}, {58'd0, bus.CDB_tag}, {58'd0, t});
    chk({name, "_data"}, {32'd0, bus.CDB_data}, {32'd0, d});
  endtask

  task automatic push(input int i, input logic [5:0] t, input logic [31:0] d);
    bus.src_valid[i]          = 1'b1;
    bus.src_tag[i*6 +: 6]     = t;
    bus.src_data[i*32 +: 32]  = d;
  endtask

  task automatic clr(input int i);
    bus.src_valid[i] = 1'b0;
  endtask

  logic [5:0]  fair_tag [6] = '{6'h00, 6'h10, 6'h3F, 6'h11, 6'h12, 6'h13};
  logic [31:0] fair_dat [6] = '{32'h0, 32'h10, 32'h3F3F3F3F, 32'h11, 32'h12, 32'h13};
  logic [5:0]  t0;
  logic        acc;

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.src_valid = '0;
    bus.src_tag   = '0;
    bus.src_data  = '0;

    // Reset and single push with two-cycle latency
    tick();
    chk("rst_ready", {60'd0, bus.src_ready}, 64'h0);
    chk_cdb("rst_cdb", 1'b0, 6'h00, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("rel_ready", {60'd0, bus.src_ready}, 64'hF);
    push(2, 6'h15, 32'hDEADBEEF);
    tick();
    clr(2);
    chk_cdb("c4", 1'b0, 6'h00, 32'h0);
    tick();
    chk_cdb("c5", 1'b1, 6'h15, 32'hDEADBEEF);
    tick();
    chk_cdb("c6", 1'b0, 6'h00, 32'h0);

    // Round robin from rr_ptr = 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push(i, 6'(i + 1), 32'hA0000000 | 32'(i));
    tick();
    for (int i = 0; i < 4; i++) clr(i);
    chk_cdb("rr_idle", 1'b0, 6'h00, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_cdb("rr_seq", 1'b1, 6'(i + 1), 32'hA0000000 | 32'(i));
    end
    tick();
    chk_cdb("rr_end", 1'b0, 6'h00, 32'h0);
    push(1, 6'h21, 32'h21);
    push(0, 6'h20, 32'h20);
    tick();
    clr(0);
    clr(1);
    tick();
    chk_cdb("rr_wrap0", 1'b1, 6'h20, 32'h20);
    tick();
    chk_cdb("rr_wrap1", 1'b1, 6'h21, 32'h21);
    tick();
    chk_cdb("rr_wrap_idle", 1'b0, 6'h00, 32'h0);

    // Fairness: source 0 streams, source 3 pushes once (rr_ptr = 2)
    t0 = 6'h10;
    for (int c = 0; c < 6; c++) begin
      push(0, t0, {26'd0, t0});
      if (c == 1) push(3, 6'h3F, 32'h3F3F3F3F);
      else clr(3);
      #1;
      acc = bus.src_ready[0];
      if (c == 3) chk("fair_full_ready0", {63'd0, acc}, 64'h0);
      tick();
      if (acc) t0 = t0 + 6'd1;
      chk_cdb("fair_seq", (c != 0), fair_tag[c], fair_dat[c]);
    end
    clr(0);
    clr(3);
    tick();
    chk_cdb("fair_tail", 1'b1, 6'h14, 32'h14);
    tick();
    chk_cdb("fair_idle", 1'b0, 6'h00, 32'h0);

    // Full back-pressure on source 1 with source 0 ahead in rotation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(0, 6'h40, 32'h4040);
    push(1, 6'h51, 32'h5151);
    tick();
    chk_cdb("bp_b", 1'b0, 6'h00, 32'h0);
    clr(0);
    push(1, 6'h52, 32'h5252);
    #1;
    chk("bp_ready1_one", {63'd0, bus.src_ready[1]}, 64'h1);
    tick();
    chk_cdb("bp_b1", 1'b1, 6'h40, 32'h4040);
    push(1, 6'h53, 32'h5353);
    #1;
    chk("bp_ready1_full", {63'd0, bus.src_ready[1]}, 64'h0);
    tick();
    chk_cdb("bp_b2", 1'b1, 6'h51, 32'h5151);
    #1;
    chk("bp_ready1_after_pop", {63'd0, bus.src_ready[1]}, 64'h1);
    tick();
    chk_cdb("bp_b3", 1'b1, 6'h52, 32'h5252);
    clr(1);
    tick();
    chk_cdb("bp_b4", 1'b1, 6'h53, 32'h5353);
    tick();
    chk_cdb("bp_b5", 1'b0, 6'h00, 32'h0);

    // Flush with buffered entries and a same-cycle push on source 2
    push(0, 6'h60, 32'h6060);
    push(1, 6'h70, 32'h7070);
    tick();
    chk_cdb("fl_c", 1'b0, 6'h00, 32'h0);
    push(0, 6'h61, 32'h6161);
    push(1, 6'h71, 32'h7171);
    tick();
    chk_cdb("fl_c1", 1'b1, 6'h60, 32'h6060);
    clr(0);
    clr(1);
    #1;
    chk("fl_ready_pre", {60'd0, bus.src_ready}, 64'hD);
    flush = 1'b1;
    push(2, 6'h22, 32'h2222);
    #1;
    chk("fl_ready_during", {60'd0, bus.src_ready}, 64'h0);
    tick();
    flush = 1'b0;
    clr(2);
    chk_cdb("fl_next", 1'b0, 6'h00, 32'h0);
    #1;
    chk("fl_ready_after", {60'd0, bus.src_ready}, 64'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cdb("fl_quiet", 1'b0, 6'h00, 32'h0);
    end

    // Reset in the middle of a four-source stream (rr_ptr = 1)
    for (int i = 0; i < 4; i++) push(i, 6'h30 + 6'(i), 32'hC0DE0000 | 32'(i));
    tick();
    chk_cdb("ms_d", 1'b0, 6'h00, 32'h0);
    tick();
    chk_cdb("ms_d1", 1'b1, 6'h31, 32'hC0DE0001);
    tick();
    chk_cdb("ms_d2", 1'b1, 6'h32, 32'hC0DE0002);
    reset = 1'b1;
    #1;
    chk("ms_ready_rst", {60'd0, bus.src_ready}, 64'h0);
    tick();
    chk_cdb("ms_rst", 1'b0, 6'h00, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) clr(i);
    #1;
    chk("ms_ready_rel", {60'd0, bus.src_ready}, 64'hF);
    push(3, 6'h0F, 32'hF0F0);
    push(0, 6'h0E, 32'hE0E0);
    tick();
    clr(0);
    clr(3);
    chk_cdb("ms_r0", 1'b0, 6'h00, 32'h0);
    tick();
    chk_cdb("ms_r1", 1'b1, 6'h0E, 32'hE0E0);
    tick();
    chk_cdb("ms_r2", 1'b1, 6'h0F, 32'hF0F0);
    tick();
    chk_cdb("ms_r3", 1'b0, 6'h00, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Result-broadcast side of the integer issue queue. Up to four functional-unit result sources (ALU, shifter, multiplier, load unit) push `{tag, data}` results into per-source 2-entry buffers. A round-robin arbiter selects one result per cycle and drives the registered Common Data Bus (`CDB_valid`, `CDB_tag`, `CDB_data`). Issue-queue entries snoop this bus to wake pending operands.

## Interface
Parameters:
- `NUM_SRC`, 4: number of result sources (fixed at 4 in this revision).
- `TAG_W`, 6: physical tag width; matches issue-queue tags.
- `DATA_W`, 32: result data width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: pipeline flush (mispredict); discards buffered and in-flight results.
- `src_valid` in NUM_SRC: source i presents a result.
- `src_tag` in NUM_SRC*TAG_W: source i tag in bits [i*TAG_W +: TAG_W].
- `src_data` in NUM_SRC*DATA_W: source i data in bits [i*DATA_W +: DATA_W].
- `src_ready` out NUM_SRC: source i buffer can accept a result this cycle.
- `CDB_valid` out 1: broadcast valid.
- `CDB_tag` out TAG_W: broadcast tag.
- `CDB_data` out DATA_W: broadcast data.

## Operation
- Per-source 2-entry FIFO with a count of 0..2. `src_ready[i] = (count_i < 2) && !reset && !flush`, derived from the registered count only.
- A push happens when `src_valid[i] && src_ready[i]`. The push is blocked while full, even if a pop of that FIFO occurs in the same cycle; a full FIFO accepts nothing that cycle.
- A pop happens when source i is granted. Simultaneous push and pop on a FIFO with count 1 leaves count at 1 and the order is preserved.
- Arbiter:
  - The request vector is `count_i != 0`.
  - Round-robin pointer `rr_ptr` (2 bits, reset 0). Search order is rr_ptr, rr_ptr+1, …, wrapping mod 4.
  - On a grant to i, set `rr_ptr <= (i+1) mod 4`.
  - With no requests, rr_ptr is unchanged.
  - At most one grant per cycle. The CDB never stalls.
- Output register:
  - `CDB_valid <= grant_any`. `CDB_tag` and `CDB_data` load the granted FIFO head.
  - When no grant occurs, tag and data are driven to 0.
- Flush:
  - All counts go to 0, `CDB_valid <= 0`, and `rr_ptr` is held.
  - Flush has priority over a same-cycle push (the push is dropped; `src_ready` is 0) and over a same-cycle grant (no broadcast).
- Reset: all counts 0, `rr_ptr = 0`, `CDB_valid = 0`, `CDB_tag = 0`, `CDB_data = 0`, `src_ready = 0` while reset is high.

## Timing
- Latency from a push accepted in cycle N into an empty FIFO with no competition to `CDB_valid` is 2 cycles: the FIFO is written at the end of N, granted in N+1, and the CDB is visible in N+2.
- Sustained throughput is one broadcast per cycle across all sources. Each source gets at least one grant every 4 cycles while it is non-empty.
- `src_ready` reflects the count after the previous edge. Sources may hold `src_valid` across cycles; each accepted handshake is a distinct result.
- `reset` or `flush` asserted in cycle N clears state at the end of N. `CDB_valid` is 0 in N+1 and `src_ready` is 1 in N+1 (if the signal is deasserted).

## Structure
- A shared package holds `TAG_W`, `DATA_W`, `NUM_SRC`, and the typedef `cdb_pkt_t {logic [TAG_W-1:0] tag; logic [DATA_W-1:0] data;}`. The issue queue uses the same package.
- Sub-module `cdb_src_fifo`: 2-entry FIFO with push, pop, flush, count, head, and ready, instantiated NUM_SRC times.
- The arbiter and output register live in `cdb_arbiter` itself.

## Test plan
- Reset and single push:
  - Stimulus: reset for 2 cycles; then source 2 pushes tag 0x15, data 0xDEADBEEF in cycle 3.
  - Required response: `CDB_valid=1`, `CDB_tag=0x15`, `CDB_data=0xDEADBEEF` in cycle 5 only, with outputs 0 in all other cycles.
- Round robin:
  - Stimulus: all four sources push tags 0x01–0x04 in the same cycle, starting from `rr_ptr=0`.
  - Required response: tags broadcast in order 0x01, 0x02, 0x03, 0x04 on consecutive cycles, and `rr_ptr` returns to 0.
- Fairness:
  - Stimulus: source 0 pushes continuously (tags 0x10, 0x11, …) while source 3 pushes 0x3F once.
  - Required response: 0x3F broadcast within 2 cycles of its arrival at the FIFO head, and source 0 is never starved.
- Full back-pressure:
  - Stimulus: source 1 pushes 3 results back-to-back while source 0 holds priority.
  - Required response: `src_ready[1]` deasserts after 2 accepts, and the third result is accepted only after a pop. All three tags are broadcast in order with none lost or duplicated.
- Flush:
  - Stimulus: fill sources 0 and 1 with 2 entries each, then assert `flush` for 1 cycle together with a new push on source 2.
  - Required response: `CDB_valid=0` the next cycle, all counts 0, and the source-2 result is never broadcast.
- Reset mid-stream:
  - Stimulus: assert `reset` during a continuous 4-source stream.
  - Required response: outputs are 0 the following cycle, and after reset release arbitration restarts at source 0.
